change_dispense_ctrl: RTL
=========================

Name: change_dispense_ctrl

Overview:
- Sequences physical change return for the vending machine after a purchase session ends.
- Owns the inactivity countdown. On timeout or an explicit return request, it snapshots the current balance and dispenses coins greedily, one at a time, to the coin hopper over a valid/ready handshake.
- Reports each dispensed amount so the balance register can be debited.
- Sits between the balance/total logic and the coin hopper interface.

Parameters:
- TOTAL_W, 31, width of balance and amount buses.
- COIN_VAL0, 100, value of coin index 0.
- COIN_VAL1, 500, value of coin index 1.
- COIN_VAL2, 1000, value of coin index 2.
- WAIT_CYCLES, 10, inactivity timeout in clk cycles.
- HOPPER_TIMEOUT, 64, max cycles waiting for hopper ready (only with CHANGE_WATCHDOG_EN).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- i_activity  in  1  one-cycle pulse on any coin insert or item select.
- i_return_req  in  1  one-cycle pulse, user pressed return.
- i_total  in  TOTAL_W  current balance.
- o_wait_time  out  32  remaining inactivity cycles.
- o_busy  out  1  high in LATCH/SELECT/DISPENSE/DONE; upstream blocks coin/select while high.
- o_disp_valid  out  1  coin dispense request.
- o_disp_coin  out  3  one-hot coin index, stable while o_disp_valid.
- i_disp_ready  in  1  hopper accepted coin.
- o_debit_valid  out  1  one-cycle pulse, debit balance.
- o_debit_amt  out  TOTAL_W  amount to debit, valid with o_debit_valid.
- o_done  out  1  one-cycle pulse, dispense sequence finished.
- o_residue  out  TOTAL_W  undispensable remainder, valid with o_done.
- o_fault  out  1  one-cycle pulse, hopper watchdog abort.

Behaviour:
- Reset (reset_n low at posedge): state IDLE; o_wait_time=0; remaining=0; all valid/pulse outputs 0; o_disp_coin=0; o_debit_amt=0; o_residue=0.
- Reset mid-dispense drops o_disp_valid next edge. No debit is issued for the in-flight coin.

States and transitions:
- IDLE
  - i_activity → COUNT, o_wait_time=WAIT_CYCLES.
  - i_return_req with i_total>0 → LATCH.
  - If both arrive in the same cycle, i_return_req wins.
- COUNT
  - i_activity reloads WAIT_CYCLES.
  - Otherwise o_wait_time decrements by 1 per cycle.
  - i_return_req → LATCH regardless of count.
  - Count reaches 0 → LATCH if i_total>0, else IDLE.
- LATCH (1 cycle): remaining←i_total; o_wait_time←0; → SELECT.
- SELECT (1 cycle, combinational greedy choice):
  - Pick the largest COIN_VALk ≤ remaining.
  - If one exists: drive o_disp_coin one-hot, o_disp_valid=1, → DISPENSE.
  - If none (remaining < COIN_VAL0): → DONE.
- DISPENSE
  - o_disp_valid and o_disp_coin held stable until i_disp_ready is sampled high at a posedge.
  - On that edge: remaining -= coin value; o_debit_valid=1 with o_debit_amt=coin value for exactly one cycle; o_disp_valid drops; → SELECT.
  - i_disp_ready while not valid is ignored.
- DONE (1 cycle): o_done=1, o_residue=remaining; → IDLE.

Rules:
- i_activity and i_return_req are ignored while o_busy.
- Throughput: at most 1 coin per 2 cycles (SELECT + DISPENSE).
- Arithmetic is unsigned TOTAL_W. Subtraction never underflows because the coin is only chosen when its value ≤ remaining.
- remaining=0 after the last coin → SELECT → DONE with residue 0.
- Coin values are compared in descending order. Ties are impossible given distinct parameters.

Optional Feature:
- CHANGE_WATCHDOG_EN defined:
  - A counter runs in DISPENSE; it clears on entering DISPENSE.
  - If HOPPER_TIMEOUT cycles pass without i_disp_ready: drop o_disp_valid, pulse o_fault, → DONE with o_residue=remaining (no debit for that coin).
- Undefined: DISPENSE waits indefinitely; o_fault tied 0; no counter logic.

Decomposition:
- Shared package/def include: coin count (3), coin value constants, TOTAL_W, state encoding localparams (IDLE, COUNT, LATCH, SELECT, DISPENSE, DONE).
- One natural sub-module: coin_greedy_sel. It is combinational: remaining → one-hot coin plus value plus found flag.

Test Plan:
- i_activity pulse, i_total=1600, no further activity → o_wait_time 10→0; then o_disp_coin 100b, 010b, 001b in order (ready tied 1); debits 1000, 500, 100; o_done with o_residue=0.
- i_activity at cycle 0 and again at cycle 5 → o_wait_time reloads to 10 at cycle 6; LATCH occurs 10 cycles after the second pulse.
- i_return_req with i_total=650 → coins 500, 100; o_done with o_residue=50; o_wait_time=0.
- i_disp_ready held low for 5 cycles during the first coin → o_disp_valid/o_disp_coin stable for all 5 cycles; exactly one debit after ready.
- Reset asserted mid-DISPENSE (i_total=1000) → next edge all outputs 0, no debit, state IDLE; timeout with i_total=0 → back to IDLE, no dispense.
- CHANGE_WATCHDOG_EN, HOPPER_TIMEOUT=64, ready never asserted, i_total=500 → o_fault pulse after 64 cycles in DISPENSE; o_done with o_residue=500.

Source files
------------

// File: rtl/change_dispense_ctrl_pkg.sv
// Shared definitions for the change dispense controller: coin table,
// bus widths, timing defaults and the controller state encoding.
package change_dispense_ctrl_pkg;

    // Number of coin denominations handled by the hopper.
    localparam int COIN_N = 3;

    // Default widths, coin values and timing.
    localparam int DEF_TOTAL_W        = 31;
    localparam int DEF_COIN_VAL0      = 100;
    localparam int DEF_COIN_VAL1      = 500;
    localparam int DEF_COIN_VAL2      = 1000;
    localparam int DEF_WAIT_CYCLES    = 10;
    localparam int DEF_HOPPER_TIMEOUT = 64;

    // Controller state encoding, also exported on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COUNT    = 3'd1,
        ST_LATCH    = 3'd2,
        ST_SELECT   = 3'd3,
        ST_DISPENSE = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Upstream must hold off coin insert / item select in these states.
    function automatic logic state_busy(state_t s);
        return (s == ST_LATCH) || (s == ST_SELECT) ||
               (s == ST_DISPENSE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_coin_greedy_sel.sv
// Greedy coin chooser: picks the largest coin whose value fits in the
// remaining balance. Purely combinational.
module coin_greedy_sel
    import change_dispense_ctrl_pkg::*;
#(
    parameter int TOTAL_W   = DEF_TOTAL_W,
    parameter int COIN_VAL0 = DEF_COIN_VAL0,
    parameter int COIN_VAL1 = DEF_COIN_VAL1,
    parameter int COIN_VAL2 = DEF_COIN_VAL2
) (
    input  logic [TOTAL_W-1:0] remaining,
    output logic [COIN_N-1:0]  coin,
    output logic [TOTAL_W-1:0] value,
    output logic               found
);

    localparam logic [TOTAL_W-1:0] V0 = TOTAL_W'(COIN_VAL0);
    localparam logic [TOTAL_W-1:0] V1 = TOTAL_W'(COIN_VAL1);
    localparam logic [TOTAL_W-1:0] V2 = TOTAL_W'(COIN_VAL2);

    // Compare in descending coin value; the first fit wins.
    always_comb begin
        coin  = '0;
        value = '0;
        found = 1'b0;
        if (remaining >= V2) begin
            coin[2] = 1'b1;
            value   = V2;
            found   = 1'b1;
        end else if (remaining >= V1) begin
            coin[1] = 1'b1;
            value   = V1;
            found   = 1'b1;
        end else if (remaining >= V0) begin
            coin[0] = 1'b1;
            value   = V0;
            found   = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispense controller. Runs the inactivity countdown, snapshots the
// balance on timeout or return request, then hands coins to the hopper one
// at a time and reports each debit.
// Optional hopper watchdog: define CHANGE_WATCHDOG_EN.
//
// Hopper handshake: o_disp_valid rises when a coin is offered and holds,
// with o_disp_coin stable, until i_disp_ready is sampled high at a posedge;
// that edge transfers the coin. i_disp_ready while o_disp_valid is low has
// no effect.
module change_dispense_ctrl
    import change_dispense_ctrl_pkg::*;
#(
    parameter int TOTAL_W     = DEF_TOTAL_W,
    parameter int COIN_VAL0   = DEF_COIN_VAL0,
    parameter int COIN_VAL1   = DEF_COIN_VAL1,
    parameter int COIN_VAL2   = DEF_COIN_VAL2,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
`ifdef CHANGE_WATCHDOG_EN
    ,
    parameter int HOPPER_TIMEOUT = DEF_HOPPER_TIMEOUT
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_activity,
    input  logic               i_return_req,
    input  logic [TOTAL_W-1:0] i_total,
    output logic [31:0]        o_wait_time,
    output logic               o_busy,
    output logic               o_disp_valid,
    output logic [COIN_N-1:0]  o_disp_coin,
    input  logic               i_disp_ready,
    output logic               o_debit_valid,
    output logic [TOTAL_W-1:0] o_debit_amt,
    output logic               o_done,
    output logic [TOTAL_W-1:0] o_residue,
    output logic               o_fault,
    output logic [2:0]         o_state_dbg
);

    state_t               state_q, state_d;
    logic [31:0]          wait_q;
    logic [TOTAL_W-1:0]   remaining_q;
    logic [COIN_N-1:0]    coin_q;
    logic [TOTAL_W-1:0]   coin_val_q;
    logic                 debit_valid_q;
    logic [TOTAL_W-1:0]   debit_amt_q;
    logic                 fault_q;

    logic [COIN_N-1:0]    sel_coin;
    logic [TOTAL_W-1:0]   sel_val;
    logic                 sel_found;
    logic                 total_nz;
    logic                 accept;
    logic                 wd_expire;

    coin_greedy_sel #(
        .TOTAL_W   (TOTAL_W),
        .COIN_VAL0 (COIN_VAL0),
        .COIN_VAL1 (COIN_VAL1),
        .COIN_VAL2 (COIN_VAL2)
    ) u_sel (
        .remaining (remaining_q),
        .coin      (sel_coin),
        .value     (sel_val),
        .found     (sel_found)
    );

    assign total_nz = |i_total;
    assign accept   = (state_q == ST_DISPENSE) && i_disp_ready;

`ifdef CHANGE_WATCHDOG_EN
    localparam int WD_W = $clog2(HOPPER_TIMEOUT) + 1;
    logic [WD_W-1:0] wd_cnt_q;

    // Give up on the hopper after HOPPER_TIMEOUT cycles without ready.
    assign wd_expire = (state_q == ST_DISPENSE) && !i_disp_ready &&
                       (wd_cnt_q == WD_W'(HOPPER_TIMEOUT - 1));

    // Watchdog counter: cleared on entry to DISPENSE, counts while there.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
        end else if (state_d == ST_DISPENSE && state_q != ST_DISPENSE) begin
            wd_cnt_q <= '0;
        end else if (state_q == ST_DISPENSE) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; return request has priority over activity.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_return_req) begin
                    state_d = total_nz ? ST_LATCH : ST_IDLE;
                end else if (i_activity) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (i_return_req) begin
                    state_d = ST_LATCH;
                end else if (i_activity) begin
                    state_d = ST_COUNT;
                end else if (wait_q <= 32'd1) begin
                    state_d = total_nz ? ST_LATCH : ST_IDLE;
                end
            end
            ST_LATCH:  state_d = ST_SELECT;
            ST_SELECT: state_d = sel_found ? ST_DISPENSE : ST_DONE;
            ST_DISPENSE: begin
                if (i_disp_ready) begin
                    state_d = ST_SELECT;
                end else if (wd_expire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: countdown, balance snapshot, chosen coin and debit pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_q        <= '0;
            remaining_q   <= '0;
            coin_q        <= '0;
            coin_val_q    <= '0;
            debit_valid_q <= 1'b0;
            debit_amt_q   <= '0;
            fault_q       <= 1'b0;
        end else begin
            debit_valid_q <= 1'b0;
            fault_q       <= wd_expire;

            if (i_activity && state_d == ST_COUNT) begin
                wait_q <= 32'(WAIT_CYCLES);
            end else if (state_d == ST_LATCH) begin
                wait_q <= '0;
            end else if (state_q == ST_COUNT && wait_q != 32'd0) begin
                wait_q <= wait_q - 32'd1;
            end

            if (state_q == ST_LATCH) begin
                remaining_q <= i_total;
            end else if (accept) begin
                remaining_q <= remaining_q - coin_val_q;
            end

            if (state_q == ST_SELECT && sel_found) begin
                coin_q     <= sel_coin;
                coin_val_q <= sel_val;
            end

            if (accept) begin
                debit_valid_q <= 1'b1;
                debit_amt_q   <= coin_val_q;
            end
        end
    end

    // Outputs decoded from state; coin and residue are masked outside
    // the cycles in which they are meaningful.
    always_comb begin
        o_busy       = state_busy(state_q);
        o_disp_valid = (state_q == ST_DISPENSE);
        o_disp_coin  = (state_q == ST_DISPENSE) ? coin_q : '0;
        o_done       = (state_q == ST_DONE);
        o_residue    = (state_q == ST_DONE) ? remaining_q : '0;
        o_state_dbg  = state_q;
    end

    assign o_wait_time   = wait_q;
    assign o_debit_valid = debit_valid_q;
    assign o_debit_amt   = debit_amt_q;
    assign o_fault       = fault_q;

endmodule
